mailbox_reader: RTL and testbench
=================================

// Module: mailbox_reader
// PURPOSE
//  Read-side agent for the 42-bit single-entry clock-crossing mailbox. Runs in
//  the consumer clock domain and synchronises the mailbox rd_valid flag. It
//  pops one word at a time with a one-cycle rd_en pulse and stores words in a
//  local DEPTH-entry queue. The queue drives a downstream valid/ready stream,
//  for example into decode.
// PARAMETERS
//  WIDTH        42  mailbox word width.
//  DEPTH        4   local queue entries; power of two, >=2.
//  SYNC_STAGES  2   flops in the rd_valid synchroniser; >=2.
//  CNT_W        16  width of the words_rx counter.
// PORTS
//  clk        in   1          consumer clock; the same clock as the mailbox rd_clk.
//  rst_n      in   1          asynchronous reset, active low.
//  rd_valid   in   1          mailbox full flag; asynchronous to clk.
//  rd_en      out  1          mailbox pop strobe; registered.
//  rd_data    in   WIDTH      mailbox read register; valid the cycle after an rd_en edge.
//  out_valid  out  1          queue not empty.
//  out_ready  in   1          downstream accepts the head word.
//  out_data   out  WIDTH      head of the queue.
//  level      out  log2(DEPTH)+1  queue occupancy.
//  words_rx   out  CNT_W      words captured since reset; wraps modulo 2^CNT_W.
// BEHAVIOUR
//  Reset (rst_n=0, asynchronous):
//   - state=IDLE; synchroniser=0; queue pointers=0.
//   - rd_en=0, out_valid=0, level=0, words_rx=0, out_data=0.
//  The sync block is a SYNC_STAGES flop chain on rd_valid; its output is vsync.
//  FSM (registered):
//   IDLE: if vsync && level<DEPTH, go to POP.
//   POP:  rd_en=1 for exactly this cycle; go to CAPT unconditionally.
//   CAPT: write rd_data at the tail; words_rx+=1; go to HOLD, hold_cnt=SYNC_STAGES.
//   HOLD: rd_en=0; decrement hold_cnt; at 0 go to IDLE. HOLD masks the stale
//         vsync after a pop.
//  At most one pop is in flight. The level<DEPTH check in IDLE reserves the
//  slot, so CAPT never overflows the queue.
//  Latency: from rd_valid rising to out_valid=1 is SYNC_STAGES+3 clk edges
//  when the queue is empty and the FSM is in IDLE.
//  Minimum spacing between consecutive rd_en pulses: SYNC_STAGES+3 cycles.
//  Downstream: a pop occurs when out_valid && out_ready; the head pointer
//  advances; out_data shows the next entry combinationally from the array.
//  Simultaneous CAPT push and downstream pop: level is unchanged; both
//  pointers advance.
//  Queue full (level==DEPTH): the FSM stays in IDLE and does not assert rd_en.
//  The mailbox stays full, which back-pressures the writer.
//  Pointers are log2(DEPTH) bits and wrap naturally.
//  out_ready while empty: no effect. out_data is a don't-care when out_valid=0.
//  Reset mid-POP or mid-CAPT: the word may be lost, which is accepted. After
//  reset, rd_en stays 0 until vsync is re-established.
// TESTING
//  T1 reset: rst_n=0 mid-stream -> rd_en=0, out_valid=0, level=0, words_rx=0
//     in the same cycle, before the next clk edge.
//  T2 single word: rd_data=42'h2AB_CDEF_0123, rd_valid rises at cycle 0
//     (SYNC_STAGES=2) -> rd_en=1 only in cycle 3; out_valid=1 in cycle 5;
//     out_data=42'h2AB_CDEF_0123; words_rx=1.
//  T3 fill: out_ready=0 and 6 words offered -> 4 captured, level=4, no 5th
//     rd_en; then out_ready=1 -> words 1..6 drain in order.
//  T4 concurrent: the queue holds 1 word, out_ready=1 during CAPT -> level
//     stays 1 and the order is preserved.
//  T5 rd_en spacing: rd_valid held high continuously -> rd_en pulses are
//     single-cycle and exactly 5 cycles apart; no pulse occurs during HOLD.
//  T6 counter wrap: CNT_W=4, 17 words -> words_rx reads 1 after the 17th
//     capture.

Source files
------------

// File: rtl/mailbox_reader_if.sv
// Handshake bundle between the mailbox reader, the mailbox read port and the
// downstream stream consumer.
interface mailbox_reader_if #(
  parameter int WIDTH = 42
);
  logic             rd_valid;
  logic             rd_en;
  logic [WIDTH-1:0] rd_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;

  modport master (
    input  rd_valid,
    input  rd_data,
    input  out_ready,
    output rd_en,
    output out_valid,
    output out_data
  );

  modport slave (
    output rd_valid,
    output rd_data,
    output out_ready,
    input  rd_en,
    input  out_valid,
    input  out_data
  );
endinterface

// File: rtl/mailbox_reader.sv
// Consumer-domain reader for the single-entry clock-crossing mailbox: pops one
// word per handshake into a small local queue that feeds a valid/ready stream.
module mailbox_reader #(
  parameter int WIDTH       = 42,
  parameter int DEPTH       = 4,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  mailbox_reader_if.master         mb,
  output logic [$clog2(DEPTH):0]   level,
  output logic [CNT_W-1:0]         words_rx
);

  localparam int PTR_W  = $clog2(DEPTH);
  localparam int LVL_W  = PTR_W + 1;
  localparam int HOLD_W = $clog2(SYNC_STAGES + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_POP  = 2'd1,
    S_CAPT = 2'd2,
    S_HOLD = 2'd3
  } state_t;

  state_t              state_q;
  logic                rd_en_q;
  logic [HOLD_W-1:0]   hold_q;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                vsync_s;

  logic [WIDTH-1:0]    mem_q [DEPTH];
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]    level_q, level_d;
  logic [CNT_W-1:0]    words_q, words_d;
  logic                out_valid_q;
  logic                push_s;
  logic                pop_s;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], mb.rd_valid};
    end
  end

  assign vsync_s = sync_q[SYNC_STAGES-1];

  // HOLD outlasts the synchroniser so the pre-pop vsync is never re-used.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      rd_en_q <= 1'b0;
      hold_q  <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (vsync_s && (level_q < LVL_W'(DEPTH))) begin
            state_q <= S_POP;
            rd_en_q <= 1'b1;
          end else begin
            state_q <= S_IDLE;
            rd_en_q <= 1'b0;
          end
        end
        S_POP: begin
          state_q <= S_CAPT;
          rd_en_q <= 1'b0;
        end
        S_CAPT: begin
          state_q <= S_HOLD;
          rd_en_q <= 1'b0;
          hold_q  <= HOLD_W'(SYNC_STAGES);
        end
        S_HOLD: begin
          rd_en_q <= 1'b0;
          if (hold_q <= HOLD_W'(1)) begin
            state_q <= S_IDLE;
            hold_q  <= '0;
          end else begin
            state_q <= S_HOLD;
            hold_q  <= hold_q - HOLD_W'(1);
          end
        end
        default: begin
          state_q <= S_IDLE;
          rd_en_q <= 1'b0;
          hold_q  <= '0;
        end
      endcase
    end
  end

  assign push_s = (state_q == S_CAPT);
  assign pop_s  = out_valid_q && mb.out_ready;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    words_d  = words_q;
    level_d  = level_q;
    if (push_s) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
      words_d  = words_q + CNT_W'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
      words_d  = words_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_s, pop_s})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      words_q     <= '0;
      out_valid_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      words_q     <= words_d;
      out_valid_q <= (level_d != '0);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      if (push_s) begin
        mem_q[wr_ptr_q] <= mb.rd_data;
      end
    end
  end

  assign mb.rd_en     = rd_en_q;
  assign mb.out_valid = out_valid_q;
  assign mb.out_data  = mem_q[rd_ptr_q];
  assign level        = level_q;
  assign words_rx     = words_q;

endmodule

// File: tb/tb_mailbox_reader.sv
// Directed bench for mailbox_reader: a main instance (CNT_W=16) plus a
// CNT_W=4 instance for the counter wrap scenario.
module tb_mailbox_reader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  int          checks = 0;
  int          errors = 0;

  mailbox_reader_if #(.WIDTH(42)) mb ();
  mailbox_reader_if #(.WIDTH(42)) mb4 ();
  logic [2:0]  level, level4;
  logic [15:0] words_rx;
  logic [3:0]  words_rx4;

  mailbox_reader #(.WIDTH(42), .DEPTH(4), .SYNC_STAGES(2), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .mb(mb), .level(level), .words_rx(words_rx)
  );
  mailbox_reader #(.WIDTH(42), .DEPTH(4), .SYNC_STAGES(2), .CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .mb(mb4), .level(level4), .words_rx(words_rx4)
  );

  always #5 clk = ~clk;

  // Mailbox: manual drive, or a model that refills after each pop.
  logic        mb_en = 1'b0;
  logic        man_valid = 1'b0;
  logic [41:0] man_data = 42'h0;
  logic        mdl_valid = 1'b0;
  logic [41:0] mdl_data = 42'h0;
  logic [41:0] mb_words [16];
  int          mb_n = 0;
  int          mb_idx = 0;

  assign mb.rd_valid = mb_en ? mdl_valid : man_valid;
  assign mb.rd_data  = mb_en ? mdl_data : man_data;

  always @(negedge clk) begin
    if (mb_en) begin
      if (mb.rd_en && mdl_valid) begin
        mdl_data  = mb_words[mb_idx];
        mb_idx    = mb_idx + 1;
        mdl_valid = 1'b0;
      end else if (!mdl_valid && mb_idx < mb_n && mb_idx < 16) begin
        mdl_valid = 1'b1;
      end
    end
  end

  task automatic test_reset();
    mb.out_ready = 1'b0;
    mb4.rd_valid = 1'b0;
    mb4.rd_data = 42'h155_5555_5555;
    mb4.out_ready = 1'b1;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (mb.rd_en !== 1'b0) begin errors++; $display("FAIL reset_rd_en: got %0b expected 0", mb.rd_en); end
    checks++; if (mb.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %0b expected 0", mb.out_valid); end
    checks++; if (level !== 3'd0) begin errors++; $display("FAIL reset_level: got %0d expected 0", level); end
    checks++; if (words_rx !== 16'd0) begin errors++; $display("FAIL reset_words_rx: got %0d expected 0", words_rx); end
    checks++; if (mb.out_data !== 42'h0) begin errors++; $display("FAIL reset_out_data: got %0h expected 0", mb.out_data); end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_single();
    man_data = 42'h2AB_CDEF_0123;
    man_valid = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      @(posedge clk);
      #1;
      checks++;
      if (mb.rd_en !== (c == 3)) begin errors++; $display("FAIL single_rd_en cycle %0d: got %0b expected %0b", c, mb.rd_en, (c == 3)); end
      if (c == 4) begin
        man_valid = 1'b0;
        checks++; if (mb.out_valid !== 1'b0) begin errors++; $display("FAIL single_early_valid: got %0b expected 0", mb.out_valid); end
      end
      if (c == 5) begin
        checks++; if (mb.out_valid !== 1'b1) begin errors++; $display("FAIL single_out_valid: got %0b expected 1", mb.out_valid); end
        checks++; if (mb.out_data !== 42'h2AB_CDEF_0123) begin errors++; $display("FAIL single_out_data: got %0h expected 2abcdef0123", mb.out_data); end
        checks++; if (words_rx !== 16'd1) begin errors++; $display("FAIL single_words_rx: got %0d expected 1", words_rx); end
      end
    end
    @(negedge clk);
    mb.out_ready = 1'b1;
    @(negedge clk);
    mb.out_ready = 1'b0;
    checks++; if (level !== 3'd0) begin errors++; $display("FAIL single_drain_level: got %0d expected 0", level); end
  endtask

  task automatic test_fill();
    int pulses;
    int k;
    mb_words[0] = 42'h001_0000_0001;
    mb_words[1] = 42'h002_0000_0002;
    mb_words[2] = 42'h003_0000_0003;
    mb_words[3] = 42'h004_0000_0004;
    mb_words[4] = 42'h005_0000_0005;
    mb_words[5] = 42'h006_0000_0006;
    mb.out_ready = 1'b0;
    mb_en = 1'b1;
    mb_n = 6;
    pulses = 0;
    for (int c = 0; c < 80; c++) begin
      @(negedge clk);
      if (mb.rd_en) pulses++;
    end
    checks++; if (level !== 3'd4) begin errors++; $display("FAIL fill_level: got %0d expected 4", level); end
    checks++; if (pulses !== 4) begin errors++; $display("FAIL fill_rd_en_count: got %0d expected 4", pulses); end
    mb.out_ready = 1'b1;
    k = 0;
    for (int c = 0; c < 150 && k < 6; c++) begin
      if (mb.out_valid) begin
        checks++;
        if (mb.out_data !== mb_words[k]) begin errors++; $display("FAIL fill_order word %0d: got %0h expected %0h", k, mb.out_data, mb_words[k]); end
        k++;
      end
      @(negedge clk);
    end
    checks++; if (k !== 6) begin errors++; $display("FAIL fill_drain_count: got %0d expected 6", k); end
    repeat (3) @(negedge clk);
    checks++; if (level !== 3'd0) begin errors++; $display("FAIL fill_final_level: got %0d expected 0", level); end
    checks++; if (words_rx !== 16'd7) begin errors++; $display("FAIL fill_words_rx: got %0d expected 7", words_rx); end
    mb.out_ready = 1'b0;
  endtask

  task automatic test_concurrent();
    bit seen;
    mb_words[6] = 42'h3C3_0000_00AA;
    mb_words[7] = 42'h0F0_0000_00BB;
    mb.out_ready = 1'b0;
    mb_n = 8;
    seen = 1'b0;
    for (int c = 0; c < 40 && !seen; c++) begin
      @(negedge clk);
      if (level == 3'd1) seen = 1'b1;
    end
    checks++; if (!seen) begin errors++; $display("FAIL conc_first_word: got level %0d expected 1", level); end
    seen = 1'b0;
    for (int c = 0; c < 40 && !seen; c++) begin
      @(negedge clk);
      if (mb.rd_en) seen = 1'b1;
    end
    checks++; if (!seen) begin errors++; $display("FAIL conc_second_pop: got no rd_en expected pulse"); end
    @(negedge clk);
    checks++; if (mb.out_data !== 42'h3C3_0000_00AA) begin errors++; $display("FAIL conc_head_before: got %0h expected 3c3000000aa", mb.out_data); end
    mb.out_ready = 1'b1;
    @(posedge clk);
    #1;
    mb.out_ready = 1'b0;
    checks++; if (level !== 3'd1) begin errors++; $display("FAIL conc_level: got %0d expected 1", level); end
    checks++; if (mb.out_data !== 42'h0F0_0000_00BB) begin errors++; $display("FAIL conc_head_after: got %0h expected 0f0000000bb", mb.out_data); end
    checks++; if (mb.out_valid !== 1'b1) begin errors++; $display("FAIL conc_out_valid: got %0b expected 1", mb.out_valid); end
    @(negedge clk);
    mb.out_ready = 1'b1;
    repeat (2) @(negedge clk);
    mb.out_ready = 1'b0;
    checks++; if (level !== 3'd0) begin errors++; $display("FAIL conc_final_level: got %0d expected 0", level); end
    checks++; if (words_rx !== 16'd9) begin errors++; $display("FAIL conc_words_rx: got %0d expected 9", words_rx); end
  endtask

  task automatic test_spacing();
    int last;
    int pulses;
    logic prev;
    mb_en = 1'b0;
    man_data = 42'h0AA_5555_AAAA;
    mb.out_ready = 1'b1;
    @(negedge clk);
    man_valid = 1'b1;
    last = -1;
    pulses = 0;
    prev = 1'b0;
    for (int c = 0; c < 45; c++) begin
      @(posedge clk);
      #1;
      if (mb.rd_en) begin
        checks++;
        if (prev !== 1'b0) begin errors++; $display("FAIL spacing_width cycle %0d: got 2-cycle pulse expected 1-cycle", c); end
        if (last >= 0) begin
          checks++;
          if (c - last !== 5) begin errors++; $display("FAIL spacing_gap: got %0d expected 5", c - last); end
        end
        last = c;
        pulses++;
      end
      prev = mb.rd_en;
    end
    checks++; if (pulses < 7) begin errors++; $display("FAIL spacing_count: got %0d expected >=7", pulses); end
    @(negedge clk);
    man_valid = 1'b0;
    repeat (10) @(negedge clk);
  endtask

  task automatic test_reset_mid();
    bit seen;
    bit bad;
    mb.out_ready = 1'b0;
    man_data = 42'h1FF_0000_1234;
    man_valid = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 30 && !seen; c++) begin
      @(posedge clk);
      #1;
      if (level >= 3'd1) seen = 1'b1;
    end
    seen = 1'b0;
    for (int c = 0; c < 30 && !seen; c++) begin
      @(posedge clk);
      #1;
      if (mb.rd_en) seen = 1'b1;
    end
    checks++; if (!seen) begin errors++; $display("FAIL rstmid_pop: got no rd_en expected pulse"); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (mb.rd_en !== 1'b0) begin errors++; $display("FAIL rstmid_rd_en: got %0b expected 0", mb.rd_en); end
    checks++; if (mb.out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_out_valid: got %0b expected 0", mb.out_valid); end
    checks++; if (level !== 3'd0) begin errors++; $display("FAIL rstmid_level: got %0d expected 0", level); end
    checks++; if (words_rx !== 16'd0) begin errors++; $display("FAIL rstmid_words_rx: got %0d expected 0", words_rx); end
    man_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    bad = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (mb.rd_en) bad = 1'b1;
    end
    checks++; if (bad) begin errors++; $display("FAIL rstmid_no_pop: got rd_en pulse expected none"); end
  endtask

  task automatic test_wrap();
    int pulses;
    pulses = 0;
    @(negedge clk);
    mb4.rd_valid = 1'b1;
    for (int c = 0; c < 200 && pulses < 17; c++) begin
      @(negedge clk);
      if (mb4.rd_en) pulses++;
    end
    mb4.rd_valid = 1'b0;
    checks++; if (pulses !== 17) begin errors++; $display("FAIL wrap_pulses: got %0d expected 17", pulses); end
    checks++; if (words_rx4 !== 4'd0) begin errors++; $display("FAIL wrap_after_16: got %0d expected 0", words_rx4); end
    repeat (3) @(posedge clk);
    #1;
    checks++; if (words_rx4 !== 4'd1) begin errors++; $display("FAIL wrap_after_17: got %0d expected 1", words_rx4); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill();
    test_concurrent();
    test_spacing();
    test_reset_mid();
    test_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
